// File: rtl/dsp_result_reader.sv
// dsp_result_reader: consumer end of the DSP Mem2 result port.
// Captures one engine run into the write bank of a ping-pong buffer, then
// swaps banks so the EMIF read side always sees a complete, stable frame.
// Optional feature macro: DSP_RESULT_READER_SATURATE_EN. When it is defined,
// data reads saturate the 36-bit word to signed 32-bit. Otherwise data reads
// return the low 32 bits.
//
// Read handshake: rd_en_i is a single-cycle request with no backpressure.
// rd_valid_o follows one cycle later with rd_data_o. rd_data_o holds its
// last value while no read is in flight.
module dsp_result_reader #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 36
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  Mem2_we_i,
   input  logic [ADDR_WIDTH-1:0] Mem2_addrw_i,
   input  logic [DATA_WIDTH-1:0] Mem2_data_i,
   input  logic                  WIP_flag_i,
   input  logic                  rd_en_i,
   input  logic [ADDR_WIDTH:0]   rd_addr_i,
   output logic [31:0]           rd_data_o,
   output logic                  rd_valid_o,
   output logic                  frame_ready_o,
   output logic                  overrun_o
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

`ifdef DSP_RESULT_READER_SATURATE_EN
   localparam bit SATURATE = 1'b1;
`else
   localparam bit SATURATE = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      SWAP    = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic        wbank;       // capture bank; the read bank is ~wbank
   logic        toggle;      // run finished: flip wbank at the end of this cycle
   logic        swap;        // SWAP cycle: frame bookkeeping
   logic        mem_we;      // accepted result write
   logic        stray;       // result write outside any run
   logic        status_rd;   // read request targets the status word
   logic        unread;
   logic        overrun;
   logic [15:0] frame_cnt;
   logic [31:0] status_word;

   // Both banks in one array, indexed by {bank, address}.
   logic [DATA_WIDTH-1:0] mem [0:2*DEPTH-1];

   // Converts a stored result word to the 32-bit read format.
   // The upper bits are only inspected when saturation is built in.
   function automatic logic [31:0] convert(input logic [DATA_WIDTH-1:0] w);
      logic [DATA_WIDTH-32:0] top;
      top = w[DATA_WIDTH-1:31];
      if (SATURATE && (top != '0) && (top != '1)) begin
         return w[DATA_WIDTH-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
      return w[31:0];
   endfunction

   assign status_rd   = rd_en_i & rd_addr_i[ADDR_WIDTH];
   assign status_word = {unread, overrun, ~wbank, 13'd0, frame_cnt};
   assign overrun_o   = overrun;

   // State register and capture-bank select.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state <= IDLE;
         wbank <= 1'b0;
      end else begin
         state <= state_next;
         if (toggle) wbank <= ~wbank;
      end
   end

   // Next-state decode, write acceptance and the frame_ready pulse.
   always_comb begin
      state_next    = state;
      toggle        = 1'b0;
      swap          = 1'b0;
      mem_we        = 1'b0;
      stray         = 1'b0;
      frame_ready_o = 1'b0;
      case (state)
         IDLE: begin
            // A write arriving together with the rising WIP starts the frame.
            if (WIP_flag_i) begin
               state_next = CAPTURE;
               mem_we     = Mem2_we_i;
            end else begin
               stray = Mem2_we_i;
            end
         end
         CAPTURE: begin
            // The write on the WIP-falling cycle still lands in the old bank.
            mem_we = Mem2_we_i;
            if (!WIP_flag_i) begin
               toggle     = 1'b1;
               state_next = SWAP;
            end
         end
         SWAP: begin
            mem_we        = Mem2_we_i;
            swap          = 1'b1;
            frame_ready_o = 1'b1;
            state_next    = WIP_flag_i ? CAPTURE : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Frame counter and sticky flags. A set wins over a status-read clear.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         frame_cnt <= 16'd0;
         unread    <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (swap) begin
            frame_cnt <= frame_cnt + 16'd1;
            unread    <= 1'b1;
         end else if (status_rd) begin
            unread <= 1'b0;
         end
         if ((swap && unread) || stray) overrun <= 1'b1;
         else if (status_rd)            overrun <= 1'b0;
      end
   end

   // Result capture into the write bank; contents survive reset.
   always_ff @(posedge clk_i) begin
      if (rst_n_i && mem_we) mem[{wbank, Mem2_addrw_i}] <= Mem2_data_i;
   end

   // Read port: bank select is taken from the request cycle.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         rd_data_o  <= 32'd0;
         rd_valid_o <= 1'b0;
      end else begin
         rd_valid_o <= rd_en_i;
         if (rd_en_i) begin
            if (rd_addr_i[ADDR_WIDTH]) rd_data_o <= status_word;
            else rd_data_o <= convert(mem[{~wbank, rd_addr_i[ADDR_WIDTH-1:0]}]);
         end
      end
   end

endmodule

// File: tb/tb_dsp_result_reader.sv
// tb_dsp_result_reader: directed bench for dsp_result_reader.
// Read results go through an expected queue drained by a monitor; the
// per-scenario tasks check frame_ready_o, overrun_o and hold behaviour inline.
module tb_dsp_result_reader;

   localparam int AW = 9;
   localparam int DW = 36;
   localparam logic [AW:0] STATUS_ADDR = 10'h200;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          we;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic          wip;
   logic          rd_en;
   logic [AW:0]   rd_addr;
   logic [31:0]   rd_data;
   logic          rd_valid;
   logic          frame_ready;
   logic          overrun;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   logic [31:0] mon_exp;

   // Reference state kept by the bench
   logic [DW-1:0] mdl [0:1][0:(1<<AW)-1];
   logic          m_wbank;
   logic [15:0]   m_cnt;
   logic          m_unread;
   logic          m_overrun;
   logic          fr_pulse;
   logic          fr_after;

   dsp_result_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .Mem2_we_i     (we),
      .Mem2_addrw_i  (waddr),
      .Mem2_data_i   (wdata),
      .WIP_flag_i    (wip),
      .rd_en_i       (rd_en),
      .rd_addr_i     (rd_addr),
      .rd_data_o     (rd_data),
      .rd_valid_o    (rd_valid),
      .frame_ready_o (frame_ready),
      .overrun_o     (overrun)
   );

   // Clock
   always #5 clk = ~clk;

   // Scoreboard: every valid read result is matched against the queue head
   always @(negedge clk) begin
      if (rst_n && rd_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: rd_valid with nothing pending, rd_data=%h", rd_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (rd_data !== mon_exp) begin
               errors++;
               $display("FAIL rd_data: got %h expected %h", rd_data, mon_exp);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] stat_word();
      return {m_unread, m_overrun, ~m_wbank, 13'd0, m_cnt};
   endfunction

   task automatic swap_model();
      if (m_unread) m_overrun = 1'b1;
      m_unread = 1'b1;
      m_cnt    = m_cnt + 16'd1;
   endtask

   task automatic start_frame();
      wip = 1'b1;
      tick();
   endtask

   task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
      we = 1'b1; waddr = a; wdata = d;
      tick();
      we = 1'b0;
      mdl[m_wbank][a] = d;
   endtask

   // Drops WIP (optionally with a last write), then steps through SWAP.
   task automatic end_frame(input bit with_wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      wip = 1'b0;
      if (with_wr) begin
         we = 1'b1; waddr = a; wdata = d;
         mdl[m_wbank][a] = d;
      end
      tick();
      we = 1'b0;
      m_wbank  = ~m_wbank;
      fr_pulse = frame_ready;
      tick();
      fr_after = frame_ready;
      swap_model();
   endtask

   task automatic issue_read(input logic [AW:0] a, input logic [31:0] e);
      exp_q.push_back(e);
      rd_en = 1'b1; rd_addr = a;
      tick();
      rd_en = 1'b0;
      if (a[AW]) begin
         m_unread  = 1'b0;
         m_overrun = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; wip = 1'b0;
      rd_en = 1'b0; rd_addr = '0;
      tick(); tick();
      checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
      checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL reset_frame_ready: got %b expected 0", frame_ready); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
      rst_n = 1'b1;
      m_wbank = 1'b0; m_cnt = 16'd0; m_unread = 1'b0; m_overrun = 1'b0;
      tick();
   endtask

   task automatic test_capture();
      start_frame();
      write_word(9'd5, 36'h0_0000_0123);
      write_word(9'd511, 36'hF_FFFF_FFFE);
      checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL cap_no_early_ready: got %b expected 0", frame_ready); end
      end_frame(1'b0, 9'd0, 36'd0);
      checks++; if (fr_pulse !== 1'b1) begin errors++; $display("FAIL cap_frame_ready: got %b expected 1", fr_pulse); end
      checks++; if (fr_after !== 1'b0) begin errors++; $display("FAIL cap_ready_width: got %b expected 0", fr_after); end
      // back-to-back data reads, then status
      issue_read(10'd5, 32'h0000_0123);
      issue_read(10'd511, 32'hFFFF_FFFE);
      issue_read(STATUS_ADDR, 32'h8000_0001);
      tick();
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL cap_valid_drop: got %b expected 0", rd_valid); end
      checks++; if (rd_data !== 32'h8000_0001) begin errors++; $display("FAIL cap_data_hold: got %h expected 80000001", rd_data); end
   endtask

   task automatic test_saturation();
      start_frame();
      write_word(9'd1, 36'h7_0000_0000);
      write_word(9'd2, 36'h8_0000_0000);
      end_frame(1'b0, 9'd0, 36'd0);
      checks++; if (fr_pulse !== 1'b1) begin errors++; $display("FAIL sat_frame_ready: got %b expected 1", fr_pulse); end
`ifdef DSP_RESULT_READER_SATURATE_EN
      issue_read(10'd1, 32'h7FFF_FFFF);
      issue_read(10'd2, 32'h8000_0000);
`else
      issue_read(10'd1, 32'h0000_0000);
      issue_read(10'd2, 32'h0000_0000);
`endif
      issue_read(STATUS_ADDR, stat_word());
   endtask

   task automatic test_overrun();
      start_frame();
      write_word(9'd10, 36'h111);
      end_frame(1'b0, 9'd0, 36'd0);
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_first_frame: got %b expected 0", overrun); end
      start_frame();
      write_word(9'd10, 36'h222);
      end_frame(1'b0, 9'd0, 36'd0);
      checks++; if (fr_pulse !== 1'b1) begin errors++; $display("FAIL ovr_frame_ready: got %b expected 1", fr_pulse); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun); end
      issue_read(10'd10, 32'h0000_0222);
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
      issue_read(STATUS_ADDR, stat_word());
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
   endtask

   task automatic test_stray();
      // Known contents at address 20 in both banks
      start_frame(); write_word(9'd20, 36'hAAA); end_frame(1'b0, 9'd0, 36'd0);
      issue_read(STATUS_ADDR, stat_word());
      start_frame(); write_word(9'd20, 36'hBBB); end_frame(1'b0, 9'd0, 36'd0);
      issue_read(STATUS_ADDR, stat_word());
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL stray_pre: got %b expected 0", overrun); end
      // Stray write while idle
      we = 1'b1; waddr = 9'd20; wdata = 36'h999;
      tick();
      we = 1'b0;
      m_overrun = 1'b1;
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL stray_overrun: got %b expected 1", overrun); end
      issue_read(STATUS_ADDR, stat_word());
      // Next frame skips address 20 and writes 22 on the WIP-falling cycle
      start_frame();
      write_word(9'd21, 36'hCCC);
      end_frame(1'b1, 9'd22, 36'hDDD);
      checks++; if (fr_pulse !== 1'b1) begin errors++; $display("FAIL stray_frame_ready: got %b expected 1", fr_pulse); end
      issue_read(10'd20, mdl[!m_wbank][20][31:0]);
      issue_read(10'd21, 32'h0000_0CCC);
      issue_read(10'd22, 32'h0000_0DDD);
      issue_read(STATUS_ADDR, stat_word());
   endtask

   task automatic test_collision();
      start_frame(); write_word(9'd30, 36'h301); end_frame(1'b0, 9'd0, 36'd0);
      issue_read(STATUS_ADDR, stat_word());
      start_frame();
      write_word(9'd30, 36'h302);
      // Read on the toggle cycle sees the old frame
      wip = 1'b0;
      exp_q.push_back(mdl[!m_wbank][30][31:0]);
      rd_en = 1'b1; rd_addr = 10'd30;
      tick();
      rd_en = 1'b0;
      m_wbank = ~m_wbank;
      checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL coll_frame_ready: got %b expected 1", frame_ready); end
      // Status read in the SWAP cycle: snapshot predates the swap bookkeeping
      issue_read(STATUS_ADDR, stat_word());
      swap_model();
      checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL coll_ready_width: got %b expected 0", frame_ready); end
      issue_read(10'd30, 32'h0000_0302);
      issue_read(STATUS_ADDR, stat_word());
   endtask

   task automatic test_reset_mid();
      start_frame();
      write_word(9'd40, 36'h444);
      rst_n = 1'b0; wip = 1'b0;
      tick();
      checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_in_reset: got %b expected 0", frame_ready); end
      rst_n = 1'b1;
      m_wbank = 1'b0; m_cnt = 16'd0; m_unread = 1'b0; m_overrun = 1'b0;
      tick();
      checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL rstmid_no_ready: got %b expected 0", frame_ready); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rstmid_overrun: got %b expected 0", overrun); end
      // unread, overrun and count are zero; bit 29 shows read bank 1
      issue_read(STATUS_ADDR, 32'h2000_0000);
      start_frame();
      write_word(9'd41, 36'h541);
      end_frame(1'b0, 9'd0, 36'd0);
      checks++; if (fr_pulse !== 1'b1) begin errors++; $display("FAIL rstmid_frame_ready: got %b expected 1", fr_pulse); end
      issue_read(10'd41, 32'h0000_0541);
      issue_read(STATUS_ADDR, 32'h8000_0001);
   endtask

   initial begin
      test_reset();
      test_capture();
      test_saturation();
      test_overrun();
      test_stray();
      test_collision();
      test_reset_mid();
      tick(); tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rd_missing: %0d reads got no rd_valid, expected 0 outstanding", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
